fifo: RTL and testbench

//   Single-clock synchronous FIFO. Byte-wide by default, circular buffer with a

---
 rtl/fifo_if.sv | 34 +++
 rtl/fifo.sv | 82 ++++++++
 tb/tb_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fifo_if.sv
// Producer/consumer bundle for the synchronous fifo.
// FIFO_ERR_FLAGS_EN adds the overflow/underflow status lines.
interface fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] buf_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic [CNT_WIDTH-1:0]  fifo_counter;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output buf_in, wr_en, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  buf_out, buf_empty, buf_full, fifo_counter
  );

  modport slave (
    input  buf_in, wr_en, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output buf_out, buf_empty, buf_full, fifo_counter
  );
endinterface

// File: rtl/fifo.sv
// Single-clock circular-buffer FIFO with level counter and registered read data.
// FIFO_ERR_FLAGS_EN adds one-cycle overflow/underflow pulses.
module fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic  clk,
  input logic  rst,
  fifo_if.slave bus
);
  localparam int unsigned PtrWidth = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_out_q;
  logic                  empty, full;
  logic                  wr_acc, rd_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_WIDTH'(DEPTH));
  // A write into a full buffer is allowed when the same edge frees a slot.
  assign wr_acc = bus.wr_en & (~full | bus.rd_en);
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (rd_acc) buf_out_q <= mem[rd_ptr_q];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.buf_in;
  end

  assign bus.buf_out      = buf_out_q;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.fifo_counter = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.wr_en & full & ~bus.rd_en;
      underflow_q <= bus.rd_en & empty;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo.sv
// Randomised and directed checks of fifo against a queue-based reference model.
// Define FIFO_ERR_FLAGS_EN to also check the overflow/underflow pulses.
module tb_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_out = '0;
  logic          model_ov  = 1'b0;
  logic          model_un  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(bus.fifo_counter), 32'(model_q.size()));
    check("empty", 32'(bus.buf_empty), 32'(model_q.size() == 0));
    check("full", 32'(bus.buf_full), 32'(model_q.size() == DEPTH));
    check("buf_out", 32'(bus.buf_out), 32'(model_out));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(bus.overflow), 32'(model_ov));
    check("underflow", 32'(bus.underflow), 32'(model_un));
`endif
  endtask

  // One clock: drive at negedge, update the model at posedge, sample 1ns later.
  task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd);
    logic wr_acc, rd_acc;
    int   lvl;
    @(negedge clk);
    bus.wr_en  = wr;
    bus.buf_in = din;
    bus.rd_en  = rd;
    lvl    = model_q.size();
    rd_acc = rd && (lvl != 0);
    wr_acc = wr && ((lvl < DEPTH) || rd);
    @(posedge clk);
    model_ov = wr && (lvl == DEPTH) && !rd;
    model_un = rd && (lvl == 0);
    if (rd_acc) model_out = model_q.pop_front();
    if (wr_acc) model_q.push_back(din);
    #1;
    check_all();
  endtask

  logic [DW-1:0] exp_bytes [3];

  initial begin
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.buf_in = '0;

    // 1: reset state
    #1;
    check_all();
    #9 rst = 1'b1;
    #1;
    check_all();
    check("rst_buf_out", 32'(bus.buf_out), 32'h0);

    // 2: write 11..44, read three back
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'((i + 1) * 8'h11), 1'b0);
    check("t2_count4", 32'(bus.fifo_counter), 32'd4);
    exp_bytes[0] = 8'h11;
    exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("t2_rd", 32'(bus.buf_out), 32'(exp_bytes[i]));
    end
    check("t2_count1", 32'(bus.fifo_counter), 32'd1);

    // 3: alternating writes and reads
    exp_bytes[0] = 8'h44;
    exp_bytes[1] = 8'hAA;
    exp_bytes[2] = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, DW'(8'hAA + i * 8'h11), 1'b0);
      cycle(1'b0, '0, 1'b1);
      check("t3_rd", 32'(bus.buf_out), 32'(exp_bytes[i]));
    end
    check("t3_count1", 32'(bus.fifo_counter), 32'd1);

    // 4: drain, fill to full, overflow, drain in order
    cycle(1'b0, '0, 1'b1);
    check("t4_cc", 32'(bus.buf_out), 32'hCC);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    check("t4_full", 32'(bus.buf_full), 32'd1);
    cycle(1'b1, 8'hFF, 1'b0);
    check("t4_drop", 32'(bus.fifo_counter), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("t4_order", 32'(bus.buf_out), 32'(i));
    end
    check("t4_empty", 32'(bus.buf_empty), 32'd1);

    // 5: underflow, simultaneous access on empty and on full across the wrap
    cycle(1'b0, '0, 1'b1);
    check("t5_hold", 32'(bus.buf_out), 32'h3F);
    cycle(1'b1, 8'h5A, 1'b1);
    check("t5_empty_wr", 32'(bus.fifo_counter), 32'd1);
    check("t5_no_thru", 32'(bus.buf_out), 32'h3F);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b1);
    check("t5_full_both", 32'(bus.fifo_counter), 32'd64);

    // 6: asynchronous reset mid-stream at count=5
    while (model_q.size() > 5) cycle(1'b0, '0, 1'b1);
    check("t6_count5", 32'(bus.fifo_counter), 32'd5);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    model_out = '0;
    model_ov  = 1'b0;
    model_un  = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic: write-heavy, balanced, then read-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 250; i++) begin
        logic w, r;
        w = ($urandom_range(0, 99) < (ph == 0 ? 85 : (ph == 1 ? 50 : 20)));
        r = ($urandom_range(0, 99) < (ph == 0 ? 25 : (ph == 1 ? 50 : 85)));
        cycle(w, DW'($urandom), r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
